// File: rtl/fetch_unit.sv
// Instruction-fetch front end: loads the reset vector, then streams sequential bytes into a prefetch queue.
// Optional page-boundary pulse is enabled by defining FETCH_PAGE_CROSS_EN.
module fetch_unit #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC,
  parameter int                    QUEUE_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_read,
  input  logic                  ready,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read_write,
  output logic [DATA_WIDTH-1:0] byte_out,
  output logic                  byte_valid,
  input  logic                  byte_take,
  output logic [ADDR_WIDTH-1:0] head_pc,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic                  page_cross
);

  typedef enum logic [1:0] {VEC_LO, VEC_HI, RUN} state_t;

  localparam int PW = $clog2(QUEUE_DEPTH);

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   fetch_addr;
  logic [DATA_WIDTH-1:0]   vec_lo;
  logic [2*DATA_WIDTH-1:0] vec_word;
  logic [DATA_WIDTH-1:0]   q_data [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]   q_pc   [QUEUE_DEPTH];
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [PW:0]             count;
  logic                    in_run, full, push, pop;

  assign read_write = 1'b1;
  assign in_run     = (state == RUN);
  assign full       = (count == (PW+1)'(QUEUE_DEPTH));
  assign byte_valid = (count != '0);
  // Flush wins over both queue operations in the same cycle.
  assign pop        = in_run && !flush && byte_take && byte_valid;
  assign push       = in_run && !flush && ready && (!full || pop);
  assign byte_out   = q_data[rd_ptr];
  assign head_pc    = q_pc[rd_ptr];
  assign vec_word   = {data_read, vec_lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= VEC_LO;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    address    = fetch_addr;
    case (state)
      VEC_LO: begin
        address = RESET_VECTOR;
        if (ready) state_next = VEC_HI;
      end
      VEC_HI: begin
        address = RESET_VECTOR + ADDR_WIDTH'(1);
        if (ready) state_next = RUN;
      end
      default: address = fetch_addr;
    endcase
  end

  // The size cast truncates or zero-extends the vector word to the address width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr <= '0;
      vec_lo     <= '0;
    end else begin
      case (state)
        VEC_LO: if (ready) vec_lo <= data_read;
        VEC_HI: if (ready) fetch_addr <= ADDR_WIDTH'(vec_word);
        default: begin
          if (flush)     fetch_addr <= target;
          else if (push) fetch_addr <= fetch_addr + ADDR_WIDTH'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (in_run && flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_data[wr_ptr] <= data_read;
        q_pc[wr_ptr]   <= fetch_addr;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PAGE_CROSS_EN
  logic page_cross_q;

  // Pulses after fetching the last byte of a 256-byte page; redirects never pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) page_cross_q <= 1'b0;
    else     page_cross_q <= push && (fetch_addr[7:0] == 8'hFF);
  end

  assign page_cross = page_cross_q;
`else
  assign page_cross = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared against a queue-based reference model of the fetch front end.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_read;
  logic        ready;
  logic [15:0] address;
  logic        read_write;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_take;
  logic [15:0] head_pc;
  logic        flush;
  logic [15:0] target;
  logic        page_cross;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int          m_phase;
  logic [15:0] m_fa;
  logic [23:0] m_q[$];
  logic        m_pulse;

  fetch_unit dut (
    .clk(clk), .rst(rst), .data_read(data_read), .ready(ready),
    .address(address), .read_write(read_write), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_take(byte_take), .head_pc(head_pc),
    .flush(flush), .target(target), .page_cross(page_cross)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    if (a == 16'hFFFC) return 8'h34;
    if (a == 16'hFFFD) return 8'h12;
    return (a[7:0] + a[15:8] * 8'd3) ^ 8'hA5;
  endfunction

  assign data_read = mem(address);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic take,
                               input logic fl, input logic [15:0] tgt);
    logic [15:0] exp_addr;
    logic        do_pop, do_push;
    rst = r; ready = rdy; byte_take = take; flush = fl; target = tgt;
    if (r) begin
      m_phase = 0; m_fa = 16'h0; m_q.delete(); m_pulse = 1'b0;
    end
    #1;
    exp_addr = (m_phase == 0) ? 16'hFFFC : (m_phase == 1) ? 16'hFFFD : m_fa;
    checkOutput("address", 32'(address), 32'(exp_addr));
    checkOutput("read_write", 32'(read_write), 32'd1);
    checkOutput("byte_valid", 32'(byte_valid), 32'(m_q.size() > 0));
`ifdef FETCH_PAGE_CROSS_EN
    checkOutput("page_cross", 32'(page_cross), 32'(m_pulse));
`else
    checkOutput("page_cross", 32'(page_cross), 32'd0);
`endif
    if (r) begin
      checkOutput("reset_byte_out", 32'(byte_out), 32'd0);
      checkOutput("reset_head_pc", 32'(head_pc), 32'd0);
    end else if (m_q.size() > 0) begin
      checkOutput("byte_out", 32'(byte_out), 32'(m_q[0][7:0]));
      checkOutput("head_pc", 32'(head_pc), 32'(m_q[0][23:8]));
    end
    if (!r) begin
      m_pulse = 1'b0;
      if (m_phase == 0) begin
        if (rdy) m_phase = 1;
      end else if (m_phase == 1) begin
        if (rdy) begin
          m_fa = {mem(16'hFFFD), mem(16'hFFFC)};
          m_phase = 2;
        end
      end else if (fl) begin
        m_q.delete();
        m_fa = tgt;
      end else begin
        do_pop  = take && (m_q.size() > 0);
        do_push = rdy && ((m_q.size() < 4) || do_pop);
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
          m_q.push_back({m_fa, mem(m_fa)});
          m_pulse = (m_fa[7:0] == 8'hFF);
          m_fa = m_fa + 16'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then vector load with a three-cycle stall in VEC_HI.
    applyStimulus(1, 1, 0, 0, 16'h0);
    applyStimulus(1, 1, 0, 0, 16'h0);
    applyStimulus(0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 16'h0);
    applyStimulus(0, 1, 0, 0, 16'h0);
    // Fill the queue with no consumer, then one pop while full.
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 16'h0);
    applyStimulus(0, 1, 1, 0, 16'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 16'h0);
    // Drain to three entries, then flush with a simultaneous take.
    applyStimulus(0, 0, 1, 0, 16'h0);
    applyStimulus(0, 1, 1, 1, 16'h8000);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 16'h0);
    // Address wrap through FFFF.
    applyStimulus(0, 1, 0, 1, 16'hFFFE);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 16'h0);
    // Page crossing by streaming, then by redirect.
    applyStimulus(0, 1, 0, 1, 16'h12FC);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 1, 0, 16'h0);
    applyStimulus(0, 1, 0, 1, 16'h1300);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 16'h0);
    // Random traffic.
    for (int i = 0; i < 300; i++)
      applyStimulus(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15) == 0, 16'($urandom));
    // Reset mid-stream and restart.
    applyStimulus(1, 1, 1, 0, 16'h0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1'($urandom_range(0, 1)), 0, 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
